// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and helpers for the adder-family blocks
package adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_WORDS = 4;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // A single-word operand still gets a 1-bit index so the counter port never collapses
    function automatic int idx_width(input int words);
        return (words > 1) ? clog2(words) : 1;
    endfunction

    localparam int DEFAULT_IDX_W = idx_width(DEFAULT_WORDS);

endpackage

// File: rtl/para_adder.sv
// rtl/para_adder.sv - combinational WIDTH-bit adder with carry in and carry out
module para_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/carry_chain_seq.sv
// rtl/carry_chain_seq.sv - multi-word add sequencer feeding one para_adder, LS word first
module carry_chain_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int WORDS = DEFAULT_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_a,
    input  logic [WIDTH-1:0] s_b,
    input  logic             s_cin,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_sum,
    output logic             m_last,
    output logic             m_cout
);

    localparam int IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic             is_first;
    logic             is_last;
    logic             accept;
    logic             consume;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    assign s_ready  = !m_valid || m_ready;
    assign accept   = s_valid && s_ready;
    assign consume  = m_valid && m_ready;
    assign is_first = (idx == '0);
    assign is_last  = (idx == LAST_IDX);
    // Word 0 takes the caller's carry; later words chain the registered carry
    assign add_cin  = is_first ? s_cin : carry_q;

    para_adder #(.WIDTH(WIDTH)) u_adder (
        .a     (s_a),
        .b     (s_b),
        .cin   (add_cin),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_sum   <= '0;
            m_last  <= 1'b0;
            m_cout  <= 1'b0;
            idx     <= '0;
            carry_q <= 1'b0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_sum   <= add_sum;
            m_last  <= is_last;
            m_cout  <= is_last & add_cout;
            // Clearing on the last word keeps carry from leaking into the next operand
            carry_q <= !is_last & add_cout;
            idx     <= is_last ? '0 : idx + IDX_W'(1);
        end else if (consume) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: doc/carry_chain_seq.md
# carry_chain_seq

Multi-word add sequencer that sits directly upstream of the team's `para_adder` and owns its carry input. It accepts wide operands as a stream of WIDTH-bit word pairs, least-significant word first, and drives each pair through one `para_adder` instance. The carry-out of each word is registered and fed back as the carry-in of the next word. The result words, plus the final carry of each operand, are emitted as a registered valid/ready stream.

## Interface
Parameters:
- WIDTH, 32, word width in bits; the width of the adder instance.
- WORDS, 4, words per operand (≥1); each operand is WORDS×WIDTH bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input word pair valid.
- s_ready  out  1  input can accept this cycle.
- s_a  in  WIDTH  operand A word.
- s_b  in  WIDTH  operand B word.
- s_cin  in  1  operand carry-in; sampled only on word 0 of an operand.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_sum  out  WIDTH  sum word.
- m_last  out  1  marks the final word (index WORDS-1) of an operand.
- m_cout  out  1  final carry-out of the operand; meaningful only when m_last=1, otherwise 0.

## Operation
- Handshake: a beat is accepted when s_valid && s_ready. An output is consumed when m_valid && m_ready.
- s_ready = !m_valid || m_ready. Single output register, no skid buffer. s_ready is combinational from m_ready.
- Beat counter `idx` runs from 0 to WORDS-1 and advances only on accept. It wraps WORDS-1 → 0.
- Carry-in to the adder:
  - idx==0: s_cin.
  - Otherwise: carry_q.
- On accept:
  - m_sum ← adder sum.
  - m_last ← (idx==WORDS-1).
  - m_cout ← adder c_out if last, else 0.
  - m_valid ← 1.
  - carry_q ← adder c_out if not last, else 0.
- Consume without accept in the same cycle: m_valid ← 0. The other output fields hold their values.
- Consume and accept in the same cycle: the register is reloaded with the new beat, and m_valid stays 1.
- While m_valid && !m_ready: m_sum, m_last and m_cout stay stable, and no beat is accepted.
- Width rule: {c_out, sum} = a + b + cin, computed WIDTH+1 bits wide, with no truncation of the carry.
- WORDS=1: every beat is both first and last. s_cin is used on every beat, and m_cout is valid on every beat.
- Reset, including mid-operand:
  - m_valid=0, m_sum=0, m_last=0, m_cout=0.
  - idx=0, carry_q=0.
  - The partial operand is discarded, and the next accepted beat is treated as word 0.
- s_cin presented on non-zero word indices is ignored.

## Timing
- Latency is 1 cycle: a beat accepted on edge N appears on m_* after edge N.
- Throughput is 1 word per cycle when m_ready is held high. An operand takes WORDS cycles.
- Carry feedback path: carry_q → adder cin → carry_q. This is a single-cycle path with no added pipeline.
- Critical path: WIDTH-bit add plus output register setup. It is bounded by the adder, not by the sequencer logic.
- s_ready is held low in the cycle reset is asserted and in the first cycle after release only if m_valid=1. Since m_valid is 0 after reset, s_ready is 1 in the first cycle after release.

## Structure
- Shared package `adder_pkg`:
  - `clog2` function.
  - Localparam `IDX_W = (WORDS>1) ? clog2(WORDS) : 1`.
  - Default WIDTH/WORDS constants reused by the adder-family blocks.
- One sub-module: `para_adder #(.WIDTH(WIDTH))`, instantiated once and purely combinational. The sequencer contributes only the counter, carry register and output register.
- No explicit FSM enum: idx encodes the state (FIRST = idx==0, MID, LAST = idx==WORDS-1).

## Test plan
All scenarios use WIDTH=8 and WORDS=4 unless noted.
- Full ripple: A words FF,FF,FF,FF; B words 01,00,00,00; cin=0 → m_sum 00,00,00,00; m_last on beat 4; m_cout=1.
- Carry-in and no overflow: A 10,20,30,40; B 01,02,03,04; cin=1 → m_sum 12,22,33,44; m_cout=0.
- Back-to-back operands with m_ready=1: first operand is FF,FF,FF,FF + 01,00,00,00; second is 00,00,00,00 + 00,00,00,00 with cin=0 → second operand's word 0 is 00 (carry not leaked across operands); sustained 1 word/cycle.
- Backpressure: drop m_ready for 3 cycles mid-operand → s_ready=0 during the stall; m_* stays stable; no beat lost or duplicated; final sums match the reference model.
- Reset after word 1 of an operand → all outputs 0. Then send a fresh operand 05,00,00,00 + 03,00,00,00, cin=0 → m_sum 08,00,00,00 with m_last on its 4th beat.
- WORDS=1: each beat FF+01 with cin=1 → m_sum=01, m_last=1, m_cout=1 on every beat.
